// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_pkg
// Description : Shared types and sizing helpers for the Ethernet TX frame
//               arbiter and its round-robin picker.
//               Contents:
//                 arb_state_t    - arbiter FSM state encoding (IDLE, XFER)
//                 grant_width()  - index width for N ports, never below 1
//                 GRANT_WIDTH    - index width for the default 4-port build
// Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // A one-port build still needs a 1-bit index so ports never collapse
    // to zero width.
    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_NUM_PORTS = 4;
    localparam int GRANT_WIDTH       = grant_width(DEFAULT_NUM_PORTS);

endpackage
`default_nettype wire

// File: rtl/eth_tx_frame_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : rr_select
// Description : Combinational round-robin priority picker. Returns the first
//               asserted request found scanning upward from last+1, wrapping
//               modulo NUM_PORTS.
//               Ports:
//                 req  [NUM_PORTS]   in  request vector
//                 last [GRANT_WIDTH] in  most recently served index
//                 idx  [GRANT_WIDTH] out selected index (0 when none)
//                 any                out at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_select #(
    parameter int NUM_PORTS   = 4,
    parameter int GRANT_WIDTH = 2
) (
    input  logic [NUM_PORTS-1:0]   req,
    input  logic [GRANT_WIDTH-1:0] last,
    output logic [GRANT_WIDTH-1:0] idx,
    output logic                   any
);

    int w_dist;
    int w_best;

    // Each requester's distance from last+1 in the circular order; the
    // smallest distance wins. This avoids indexing with a computed value.
    always_comb begin
        idx    = '0;
        any    = 1'b0;
        w_dist = 0;
        w_best = NUM_PORTS;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (req[p]) begin
                w_dist = (p + NUM_PORTS - 1 - int'(last)) % NUM_PORTS;
                if (w_dist < w_best) begin
                    w_best = w_dist;
                    idx    = GRANT_WIDTH'(p);
                    any    = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/eth_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_frame_arbiter
// Description : Frame-granular round-robin arbiter sharing one MAC TX
//               AXI-Stream input among NUM_PORTS sources. A granted port owns
//               the MAC until its tlast handshake. There is one idle
//               arbitration cycle between frames.
//               Ports:
//                 i_tx_clk, i_tx_reset         clock, sync active-high reset
//                 s_axis_tdata/tkeep/tvalid/tlast  packed per-port input
//                 s_axis_trdy                  per-port ready
//                 m_axis_*                     stream to the MAC
//                 o_grant                      currently granted port
//                 o_busy                       high while a frame is passed
//                 o_frame_cnt                  per-port saturating frame count
// Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_frame_arbiter
    import eth_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_PORTS  = 4,
    parameter int CNT_WIDTH  = 16,
    localparam int GNT_WIDTH = grant_width(NUM_PORTS)
) (
    input  logic                            i_tx_clk,
    input  logic                            i_tx_reset,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*CTRL_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [NUM_PORTS-1:0]            s_axis_trdy,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [CTRL_WIDTH-1:0]           m_axis_tkeep,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_trdy,
    output logic [GNT_WIDTH-1:0]            o_grant,
    output logic                            o_busy,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]  o_frame_cnt
);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [GNT_WIDTH-1:0] r_grant;
    logic [GNT_WIDTH-1:0] r_last;
    logic [GNT_WIDTH-1:0] w_sel_idx;
    logic                 w_sel_any;
    logic                 w_done;
    logic [CNT_WIDTH-1:0] r_cnt [NUM_PORTS];

    rr_select #(
        .NUM_PORTS   (NUM_PORTS),
        .GRANT_WIDTH (GNT_WIDTH)
    ) u_rr_select (
        .req  (s_axis_tvalid),
        .last (r_last),
        .idx  (w_sel_idx),
        .any  (w_sel_any)
    );

    always_ff @(posedge i_tx_clk) begin
        if (i_tx_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and the granted-port pass-through. In IDLE every output is
    // quiet so a frame can never start in the same cycle it is selected.
    always_comb begin
        w_state_nxt   = r_state;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_trdy   = '0;
        o_busy        = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sel_any) begin
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                o_busy = 1'b1;
                for (int k = 0; k < NUM_PORTS; k++) begin
                    if (r_grant == GNT_WIDTH'(k)) begin
                        m_axis_tdata   = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
                        m_axis_tkeep   = s_axis_tkeep[k*CTRL_WIDTH +: CTRL_WIDTH];
                        m_axis_tvalid  = s_axis_tvalid[k];
                        m_axis_tlast   = s_axis_tlast[k];
                        s_axis_trdy[k] = m_axis_trdy;
                    end
                end
                w_done = m_axis_tvalid & m_axis_trdy & m_axis_tlast;
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Grant is captured only in IDLE, so it is frozen for the whole frame
    // regardless of tvalid gaps on the owning port.
    always_ff @(posedge i_tx_clk) begin
        if (i_tx_reset) begin
            r_grant <= '0;
            r_last  <= GNT_WIDTH'(NUM_PORTS - 1);
        end else begin
            if (r_state == IDLE && w_sel_any) begin
                r_grant <= w_sel_idx;
            end
            if (w_done) begin
                r_last <= r_grant;
            end
        end
    end

    always_ff @(posedge i_tx_clk) begin
        if (i_tx_reset) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                r_cnt[k] <= '0;
            end
        end else if (w_done) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (r_grant == GNT_WIDTH'(k) && r_cnt[k] != {CNT_WIDTH{1'b1}}) begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign o_grant = r_grant;

    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
            assign o_frame_cnt[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_tx_frame_arbiter
// Description : Directed self-checking bench for eth_tx_frame_arbiter. A
//               second instance with 2-bit counters shares the stimulus and
//               exposes counter saturation quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_tx_frame_arbiter;

    logic         clk;
    logic         rst;
    logic [127:0] s_tdata;
    logic [15:0]  s_tkeep;
    logic [3:0]   s_tvalid;
    logic [3:0]   s_tlast;
    logic [3:0]   s_trdy;
    logic [31:0]  m_tdata;
    logic [3:0]   m_tkeep;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_trdy;
    logic [1:0]   grant;
    logic         busy;
    logic [63:0]  cnt;

    logic [3:0]   s_trdy2;
    logic [31:0]  m_tdata2;
    logic [3:0]   m_tkeep2;
    logic         m_tvalid2;
    logic         m_tlast2;
    logic [1:0]   grant2;
    logic         busy2;
    logic [7:0]   cnt2;

    int vectors;
    int miscompares;

    eth_tx_frame_arbiter #(.DATA_WIDTH(32), .NUM_PORTS(4), .CNT_WIDTH(16)) dut (
        .i_tx_clk(clk), .i_tx_reset(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_trdy(s_trdy),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_trdy(m_trdy),
        .o_grant(grant), .o_busy(busy), .o_frame_cnt(cnt)
    );

    eth_tx_frame_arbiter #(.DATA_WIDTH(32), .NUM_PORTS(4), .CNT_WIDTH(2)) dut_sat (
        .i_tx_clk(clk), .i_tx_reset(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_trdy(s_trdy2),
        .m_axis_tdata(m_tdata2), .m_axis_tkeep(m_tkeep2), .m_axis_tvalid(m_tvalid2),
        .m_axis_tlast(m_tlast2), .m_axis_trdy(m_trdy),
        .o_grant(grant2), .o_busy(busy2), .o_frame_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
    endtask

    task automatic drive_port(input int k, input logic [31:0] d, input logic [3:0] kp,
                              input logic v, input logic l);
        s_tdata[k*32 +: 32] = d;
        s_tkeep[k*4 +: 4]   = kp;
        s_tvalid[k]         = v;
        s_tlast[k]          = l;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] cnt_of(input int k);
        return cnt[k*16 +: 16];
    endfunction

    task automatic test_reset();
        clear_inputs();
        m_trdy = 1'b1;
        rst    = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        vectors++;
        if (m_tvalid !== 1'b0 || m_tvalid2 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tvalid actual=%b/%b required=0/0", m_tvalid, m_tvalid2);
        end
        vectors++;
        if (s_trdy !== 4'b0000 || s_trdy2 !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_trdy actual=%b/%b required=0000", s_trdy, s_trdy2);
        end
        vectors++;
        if (busy !== 1'b0 || busy2 !== 1'b0 || grant !== 2'd0 || grant2 !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_busy_grant actual=%b,%0d/%b,%0d required=0,0", busy, grant, busy2, grant2);
        end
        vectors++;
        if (cnt !== 64'd0 || cnt2 !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_cnt actual=%h/%h required=0", cnt, cnt2);
        end
        vectors++;
        if (m_tlast2 !== 1'b0 || m_tkeep2 !== 4'h0 || m_tdata2 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_sat_outputs actual=%b,%h,%h required=0,0,0", m_tlast2, m_tkeep2, m_tdata2);
        end
    endtask

    task automatic test_single_frame();
        logic [31:0] d [3];
        d[0] = 32'hA0A0_0001;
        d[1] = 32'hA0A0_0002;
        d[2] = 32'hA0A0_0003;
        clear_inputs();
        m_trdy = 1'b1;
        drive_port(2, d[0], 4'hF, 1'b1, 1'b0);
        #1;
        vectors++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0 || s_trdy !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_idle actual=v%b b%b r%b required=v0 b0 r0000", m_tvalid, busy, s_trdy);
        end
        step();
        for (int b = 0; b < 3; b++) begin
            drive_port(2, d[b], (b == 2) ? 4'h3 : 4'hF, 1'b1, b == 2);
            #1;
            vectors++;
            if (grant !== 2'd2 || s_trdy !== 4'b0100 || m_tvalid !== 1'b1) begin
                miscompares++;
                $display("FAIL single_grant beat%0d actual=g%0d r%b v%b required=g2 r0100 v1", b, grant, s_trdy, m_tvalid);
            end
            vectors++;
            if (m_tdata !== d[b] || m_tlast !== (b == 2) || m_tkeep !== ((b == 2) ? 4'h3 : 4'hF)) begin
                miscompares++;
                $display("FAIL single_data beat%0d actual=%h,l%b,k%h required=%h,l%b", b, m_tdata, m_tlast, m_tkeep, d[b], b == 2);
            end
            step();
        end
        clear_inputs();
        #1;
        vectors++;
        if (busy !== 1'b0 || cnt_of(2) !== 16'd1 || cnt_of(0) !== 16'd0) begin
            miscompares++;
            $display("FAIL single_cnt actual=b%b c2=%0d c0=%0d required=b0 c2=1 c0=0", busy, cnt_of(2), cnt_of(0));
        end
    endtask

    task automatic test_round_robin();
        int beat [4];
        int frame [4];
        logic [31:0] exp_d;
        int f;
        pulse_reset();
        m_trdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            beat[k]  = 0;
            frame[k] = 0;
        end
        for (int c = 0; c < 24; c++) begin
            for (int k = 0; k < 4; k++) begin
                drive_port(k, {8'(k), 8'(frame[k]), 16'(beat[k])}, 4'hF, 1'b1, beat[k] == 1);
            end
            #1;
            vectors++;
            if (busy !== ((c % 3) != 0)) begin
                miscompares++;
                $display("FAIL rr_gap cycle%0d actual=%b required=%b", c, busy, (c % 3) != 0);
            end
            if ((c % 3) != 0) begin
                f     = (c / 3) % 4;
                exp_d = {8'(f), 8'(c / 12), 16'(((c % 3) == 2) ? 1 : 0)};
                vectors++;
                if (grant !== 2'(f) || grant2 !== 2'(f)) begin
                    miscompares++;
                    $display("FAIL rr_grant cycle%0d actual=%0d/%0d required=%0d", c, grant, grant2, f);
                end
                vectors++;
                if (m_tdata !== exp_d || m_tdata2 !== exp_d) begin
                    miscompares++;
                    $display("FAIL rr_data cycle%0d actual=%h/%h required=%h", c, m_tdata, m_tdata2, exp_d);
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (s_trdy[k]) begin
                    if (beat[k] == 1) begin
                        beat[k] = 0;
                        frame[k]++;
                    end else begin
                        beat[k] = 1;
                    end
                end
            end
            step();
        end
        clear_inputs();
        #1;
        vectors++;
        if (cnt !== {16'd2, 16'd2, 16'd2, 16'd2} || cnt2 !== 8'b10_10_10_10) begin
            miscompares++;
            $display("FAIL rr_cnt actual=%h/%h required=0002000200020002/aa", cnt, cnt2);
        end
    endtask

    task automatic test_backpressure();
        clear_inputs();
        m_trdy = 1'b1;
        drive_port(1, 32'hB000_0000, 4'hF, 1'b1, 1'b0);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_idle actual=%b required=0", busy);
        end
        step();
        drive_port(0, 32'hAAAA_0000, 4'hF, 1'b1, 1'b1);
        #1;
        vectors++;
        if (grant !== 2'd1 || m_tdata !== 32'hB000_0000 || s_trdy !== 4'b0010) begin
            miscompares++;
            $display("FAIL bp_beat0 actual=g%0d %h r%b required=g1 b0000000 r0010", grant, m_tdata, s_trdy);
        end
        step();
        drive_port(1, 32'hB000_0001, 4'hF, 1'b1, 1'b0);
        for (int s = 0; s < 2; s++) begin
            m_trdy = 1'b0;
            #1;
            vectors++;
            if (grant !== 2'd1 || m_tdata !== 32'hB000_0001 || m_tvalid !== 1'b1 || s_trdy !== 4'b0000 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_stall%0d actual=g%0d %h v%b r%b required=g1 b0000001 v1 r0000", s, grant, m_tdata, m_tvalid, s_trdy);
            end
            step();
        end
        m_trdy = 1'b1;
        #1;
        vectors++;
        if (grant !== 2'd1 || m_tdata !== 32'hB000_0001 || s_trdy !== 4'b0010) begin
            miscompares++;
            $display("FAIL bp_resume actual=g%0d %h r%b required=g1 b0000001 r0010", grant, m_tdata, s_trdy);
        end
        step();
        drive_port(1, 32'hB000_0002, 4'hF, 1'b0, 1'b0);
        #1;
        vectors++;
        if (m_tvalid !== 1'b0 || grant !== 2'd1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_gap actual=v%b g%0d b%b required=v0 g1 b1", m_tvalid, grant, busy);
        end
        step();
        drive_port(1, 32'hB000_0002, 4'hF, 1'b1, 1'b1);
        #1;
        vectors++;
        if (grant !== 2'd1 || m_tlast !== 1'b1 || m_tdata !== 32'hB000_0002) begin
            miscompares++;
            $display("FAIL bp_last actual=g%0d l%b %h required=g1 l1 b0000002", grant, m_tlast, m_tdata);
        end
        step();
        drive_port(1, 32'h0, 4'h0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (busy !== 1'b0 || cnt_of(1) !== 16'd3) begin
            miscompares++;
            $display("FAIL bp_end actual=b%b c1=%0d required=b0 c1=3", busy, cnt_of(1));
        end
        step();
        #1;
        vectors++;
        if (grant !== 2'd0 || m_tdata !== 32'hAAAA_0000 || m_tlast !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_next actual=g%0d %h l%b required=g0 aaaa0000 l1", grant, m_tdata, m_tlast);
        end
        step();
        clear_inputs();
        #1;
        vectors++;
        if (busy !== 1'b0 || cnt_of(0) !== 16'd3) begin
            miscompares++;
            $display("FAIL bp_cnt0 actual=b%b c0=%0d required=b0 c0=3", busy, cnt_of(0));
        end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        m_trdy = 1'b1;
        drive_port(3, 32'hC300_0000, 4'hF, 1'b1, 1'b1);
        step();
        #1;
        vectors++;
        if (m_tvalid !== 1'b1 || grant !== 2'd3 || m_tdata !== 32'hC300_0000 || m_tlast !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first actual=v%b g%0d %h l%b required=v1 g3 c3000000 l1", m_tvalid, grant, m_tdata, m_tlast);
        end
        step();
        drive_port(3, 32'hC300_0001, 4'hF, 1'b1, 1'b1);
        #1;
        vectors++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_bubble actual=v%b b%b required=v0 b0", m_tvalid, busy);
        end
        step();
        #1;
        vectors++;
        if (m_tvalid !== 1'b1 || grant !== 2'd3 || m_tdata !== 32'hC300_0001) begin
            miscompares++;
            $display("FAIL b2b_second actual=v%b g%0d %h required=v1 g3 c3000001", m_tvalid, grant, m_tdata);
        end
        step();
        clear_inputs();
        #1;
        vectors++;
        if (cnt_of(3) !== 16'd2 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_cnt actual=c3=%0d b%b required=c3=2 b0", cnt_of(3), busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        m_trdy = 1'b1;
        drive_port(1, 32'hE100_0000, 4'hF, 1'b1, 1'b0);
        step();
        #1;
        vectors++;
        if (grant !== 2'd1 || m_tdata !== 32'hE100_0000) begin
            miscompares++;
            $display("FAIL rmf_beat0 actual=g%0d %h required=g1 e1000000", grant, m_tdata);
        end
        step();
        drive_port(1, 32'hE100_0001, 4'hF, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        vectors++;
        if (m_tdata !== 32'hE100_0001 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rmf_beat1 actual=%h b%b required=e1000001 b1", m_tdata, busy);
        end
        step();
        rst = 1'b0;
        drive_port(0, 32'hF000_0000, 4'hF, 1'b1, 1'b1);
        #1;
        vectors++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0 || s_trdy !== 4'b0000) begin
            miscompares++;
            $display("FAIL rmf_abort actual=v%b b%b r%b required=v0 b0 r0000", m_tvalid, busy, s_trdy);
        end
        vectors++;
        if (cnt !== 64'd0) begin
            miscompares++;
            $display("FAIL rmf_cnt actual=%h required=0", cnt);
        end
        step();
        #1;
        vectors++;
        if (grant !== 2'd0 || m_tdata !== 32'hF000_0000 || s_trdy !== 4'b0001) begin
            miscompares++;
            $display("FAIL rmf_regrant actual=g%0d %h r%b required=g0 f0000000 r0001", grant, m_tdata, s_trdy);
        end
        step();
        clear_inputs();
        #1;
        vectors++;
        if (busy !== 1'b0 || cnt_of(0) !== 16'd1) begin
            miscompares++;
            $display("FAIL rmf_done actual=b%b c0=%0d required=b0 c0=1", busy, cnt_of(0));
        end
    endtask

    task automatic test_saturation();
        pulse_reset();
        m_trdy = 1'b1;
        drive_port(0, 32'h5A5A_5A5A, 4'hF, 1'b1, 1'b1);
        for (int f = 1; f <= 4; f++) begin
            step();
            step();
            #1;
            vectors++;
            if (cnt2[1:0] !== ((f < 3) ? 2'(f) : 2'd3) || cnt_of(0) !== 16'(f)) begin
                miscompares++;
                $display("FAIL sat_frame%0d actual=%0d/%0d required=%0d/%0d", f, cnt2[1:0], cnt_of(0), (f < 3) ? f : 3, f);
            end
        end
        clear_inputs();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        m_trdy      = 1'b0;
        clear_inputs();
        test_reset();
        test_single_frame();
        test_round_robin();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_tx_frame_arbiter.md
Name: eth_tx_frame_arbiter

Overview:
- Shares the single MAC TX AXI-Stream input among NUM_PORTS upstream frame sources.
- Arbitration is round-robin at frame granularity. Once a port is granted, it owns the MAC input until its tlast beat completes.
- Sits in the i_tx_clk domain directly in front of the MAC TX s_axis interface. It never splits or interleaves frames.
- Keeps per-port saturating frame counters for status.

Parameters:
- DATA_WIDTH, 32, stream data width in bits.
- CTRL_WIDTH, DATA_WIDTH/8, tkeep width.
- NUM_PORTS, 4, number of requesters (2..8).
- CNT_WIDTH, 16, width of each per-port frame counter.

Ports:
- i_tx_clk  in  1  TX clock.
- i_tx_reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  per-port data; port k occupies slice [k*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  NUM_PORTS*CTRL_WIDTH  per-port byte enables, packed the same way.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port end of frame.
- s_axis_trdy  out  NUM_PORTS  per-port ready.
- m_axis_tdata  out  DATA_WIDTH  to the MAC.
- m_axis_tkeep  out  CTRL_WIDTH  to the MAC.
- m_axis_tvalid  out  1  to the MAC.
- m_axis_tlast  out  1  to the MAC.
- m_axis_trdy  in  1  ready from the MAC.
- o_grant  out  $clog2(NUM_PORTS)  currently granted port index.
- o_busy  out  1  high while in the XFER state.
- o_frame_cnt  out  NUM_PORTS*CNT_WIDTH  per-port count of completed frames, saturating.

Behaviour:
- Clocking and reset: one clock, i_tx_clk. Reset i_tx_reset is synchronous, active-high.
- Reset values:
  - state = IDLE
  - grant_q = 0
  - last_q = NUM_PORTS-1, so port 0 has first priority
  - all frame counters = 0
  - m_axis_tvalid = 0, s_axis_trdy = 0, o_busy = 0, o_grant = 0
- State IDLE:
  - m_axis_tvalid = 0 and all s_axis_trdy = 0.
  - If any s_axis_tvalid is high, select the first requesting port scanning from last_q+1 upward, wrapping modulo NUM_PORTS.
  - Register the selection into grant_q and go to XFER.
  - If no port is valid, stay in IDLE.
- State XFER (pure combinational pass-through of the granted port):
  - m_axis_tdata/tkeep/tvalid/tlast come from port grant_q.
  - s_axis_trdy[grant_q] = m_axis_trdy. All other s_axis_trdy = 0.
  - o_busy = 1.
- Frame completion: a handshake (m_axis_tvalid & m_axis_trdy) with m_axis_tlast = 1 causes, on the next edge:
  - state goes to IDLE;
  - last_q takes grant_q;
  - o_frame_cnt[grant_q] increments, saturating at all-ones.
- Latency and gap:
  - The tlast handshake at cycle t is followed by the IDLE arbitration cycle t+1.
  - The next frame's first beat can be presented at t+2.
  - This is a fixed one-cycle bubble between frames, including back-to-back frames from the same port.
  - From IDLE with a request at cycle t, the first beat is visible on m_axis at t+1.
- Fairness: with all ports continuously requesting, grants go 0,1,2,3,0,… A port that drops tvalid is skipped.
- Backpressure:
  - m_axis_trdy low holds every output stable; the source is responsible for holding data.
  - Grant never changes mid-frame, regardless of tvalid gaps on the granted port. A tvalid gap is passed through as m_axis_tvalid = 0.
- Simultaneous events:
  - A request arriving on another port during XFER waits for frame end.
  - A request that is deasserted in the IDLE cycle itself is not granted; only the registered selection counts.
- Reset mid-frame:
  - Immediate return to IDLE and trdy drops. The truncated frame is abandoned.
  - The MAC is responsible for its own error/abort handling.
  - Counters clear.
- Single-beat frames (tvalid & tlast on the first beat) are legal: XFER lasts exactly one handshake cycle.
- Width rule: the NUM_PORTS=1 build is legal; o_grant is then 1 bit, tied to 0.

Decomposition:
- eth_pkg: add typedef arb_state_t {IDLE, XFER} and localparam GRANT_WIDTH = $clog2(NUM_PORTS) (minimum 1).
- One sub-module: rr_select — combinational round-robin priority picker with inputs req[NUM_PORTS] and last[GRANT_WIDTH], outputs idx and any. It is reusable for the RX-side status mux.

Test Plan:
- Reset then port 2 sends a 3-beat frame with m_axis_trdy = 1:
  - IDLE 1 cycle, then o_grant = 2.
  - m_axis data matches over 3 beats; tlast is on beat 3.
  - o_frame_cnt[2] = 1; s_axis_trdy[0,1,3] stay 0.
- All 4 ports continuously offer 2-beat frames for 8 frames:
  - grant order is 0,1,2,3,0,1,2,3;
  - exactly 1 idle cycle between frames;
  - every counter = 2.
- Port 1 mid-frame with port 0 requesting and m_axis_trdy toggling 1,0,0,1:
  - outputs held during the stall;
  - no grant change until tlast;
  - port 0 granted next.
- Port 3 alone sends 2 single-beat frames back to back: beats appear at cycles t+1 and t+3; o_frame_cnt[3] = 2.
- Assert i_tx_reset on beat 2 of a 4-beat frame from port 1:
  - next cycle m_axis_tvalid = 0, o_busy = 0;
  - counters = 0;
  - port 0 wins the next arbitration.
- Preload a counter to 16'hFFFE via 2 extra frames (force, or CNT_WIDTH = 2 build): the counter saturates at all-ones and does not wrap.
